i2s_tx: RTL and testbench

- I2S transmitter (bus master). Drives ws/sdata into the I2S receiver stage of the audio path; also used as a test-pattern and loopback source.
- Accepts one stereo sample pair per frame through a valid/ready handshake. Buffers one pair ahead of the frame being shifted out.
- Serializes MSB-first with the standard one-bit I2S delay after each ws edge.

---
 rtl/i2s_tx.sv | 121 ++++++++++++
 tb/tb_i2s_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S bus-master transmitter: one stereo pair buffered ahead of the frame being shifted out.
// Every register updates on the falling edge of sclk_i, so the receiver gets half a period of setup.
module i2s_tx #(
   parameter int WIDTH = 16,
   parameter int SLOT  = 16
) (
   input  logic             sclk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] leftChan_i,
   input  logic [WIDTH-1:0] rightChan_i,
   input  logic             sampleValid_i,
   output logic             sampleReady_o,
   output logic             ws_o,
   output logic             sdata_o,
   output logic             frameStart_o,
   output logic             underrun_o
);

   localparam int FRAME = 2 * SLOT;
   localparam int CW    = $clog2(FRAME);
   localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
   logic             ready_q, ready_d;
   logic             ws_q, ws_d;
   logic             sdata_q, sdata_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;

   logic             load;
   logic             accept;
   int               pos_n;
   int               bit_k;
   logic             use_right;
   logic             in_data;
   logic [IW-1:0]    bit_idx;

   always_comb begin
      cnt_d         = cnt_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      hold_full_d   = hold_full_q;
      frame_l_d     = frame_l_q;
      frame_r_d     = frame_r_q;
      load          = (cnt_q == CNT_LAST);
      accept        = sampleValid_i & ready_q;

      if (load) begin
         cnt_d = '0;
         if (hold_full_q) begin
            frame_l_d   = hold_l_q;
            frame_r_d   = hold_r_q;
            hold_full_d = 1'b0;
         end else begin
            frame_l_d = '0;
            frame_r_d = '0;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // ready_q is 0 whenever the holding register is full, so accept never collides with a pending pair
      if (accept) begin
         hold_l_d    = leftChan_i;
         hold_r_d    = rightChan_i;
         hold_full_d = 1'b1;
      end

      ready_d       = ~hold_full_d;
      frame_start_d = load;
      underrun_d    = load & ~hold_full_q;

      // outputs are registered, so they are derived from the position being entered
      pos_n     = int'(cnt_d);
      ws_d      = (pos_n >= SLOT - 1) && (pos_n <= FRAME - 2);
      use_right = (pos_n >= SLOT);
      bit_k     = use_right ? (pos_n - SLOT) : pos_n;
      in_data   = (bit_k < WIDTH);
      bit_idx   = IW'(WIDTH - 1 - bit_k);
      sdata_d   = in_data & (use_right ? frame_r_d[bit_idx] : frame_l_d[bit_idx]);
   end

   always_ff @(negedge sclk_i) begin
      if (!rst_i) begin
         cnt_q         <= CNT_LAST;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         hold_full_q   <= 1'b0;
         frame_l_q     <= '0;
         frame_r_q     <= '0;
         ready_q       <= 1'b0;
         ws_q          <= 1'b0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         hold_full_q   <= hold_full_d;
         frame_l_q     <= frame_l_d;
         frame_r_q     <= frame_r_d;
         ready_q       <= ready_d;
         ws_q          <= ws_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign sampleReady_o = ready_q;
   assign ws_o          = ws_q;
   assign sdata_o       = sdata_q;
   assign frameStart_o  = frame_start_q;
   assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (SLOT=16 and SLOT=24) driven concurrently and compared
// every bit period against a frame-level reference model plus directed frame captures.
module tb_i2s_tx;

   localparam int W = 16;

   logic sclk = 1'b1;
   always #5 sclk = ~sclk;

   logic [1:0]   rst_n;
   logic [1:0]   valid;
   logic [1:0]   ready;
   logic [1:0]   ws;
   logic [1:0]   sd;
   logic [1:0]   fs;
   logic [1:0]   ur;
   logic [W-1:0] l_in [2];
   logic [W-1:0] r_in [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      i2s_tx #(.WIDTH(W), .SLOT(g == 0 ? 16 : 24)) u_dut (
         .sclk_i        (sclk),
         .rst_i         (rst_n[g]),
         .leftChan_i    (l_in[g]),
         .rightChan_i   (r_in[g]),
         .sampleValid_i (valid[g]),
         .sampleReady_o (ready[g]),
         .ws_o          (ws[g]),
         .sdata_o       (sd[g]),
         .frameStart_o  (fs[g]),
         .underrun_o    (ur[g])
      );
   end

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int slot_of(input int g);
      return (g == 0) ? 16 : 24;
   endfunction

   function automatic string tg(input int g, input string s);
      return $sformatf("i%0d %s", g, s);
   endfunction

   // reference model: position in frame, frame being sent, one-entry pending buffer
   int           pos     [2];
   logic [W-1:0] cur_l   [2];
   logic [W-1:0] cur_r   [2];
   logic [W-1:0] pend_l  [2];
   logic [W-1:0] pend_r  [2];
   bit           pend_v  [2];
   bit           m_ready [2];
   bit           m_fs    [2];
   bit           m_ur    [2];
   int           acc_cnt [2] = '{0, 0};

   task automatic model_step(input int g);
      int f;
      bit take;
      f = 2 * slot_of(g);
      if (!rst_n[g]) begin
         pos[g] = f - 1;
         pend_v[g] = 1'b0;
         cur_l[g] = '0;
         cur_r[g] = '0;
         m_ready[g] = 1'b0;
         m_fs[g] = 1'b0;
         m_ur[g] = 1'b0;
      end else begin
         take = valid[g] && m_ready[g];
         m_fs[g] = 1'b0;
         m_ur[g] = 1'b0;
         if (pos[g] == f - 1) begin
            pos[g] = 0;
            m_fs[g] = 1'b1;
            if (pend_v[g]) begin
               cur_l[g] = pend_l[g];
               cur_r[g] = pend_r[g];
               pend_v[g] = 1'b0;
            end else begin
               cur_l[g] = '0;
               cur_r[g] = '0;
               m_ur[g] = 1'b1;
            end
         end else begin
            pos[g] = pos[g] + 1;
         end
         if (take) begin
            pend_l[g] = l_in[g];
            pend_r[g] = r_in[g];
            pend_v[g] = 1'b1;
            acc_cnt[g] = acc_cnt[g] + 1;
         end
         m_ready[g] = !pend_v[g];
      end
   endtask

   function automatic logic exp_ws(input int g);
      int s;
      s = slot_of(g);
      return (pos[g] >= s - 1) && (pos[g] <= 2 * s - 2);
   endfunction

   function automatic logic exp_sd(input int g);
      int s;
      int k;
      logic [W-1:0] word;
      s = slot_of(g);
      k = pos[g] % s;
      word = (pos[g] < s) ? cur_l[g] : cur_r[g];
      if (k >= W) return 1'b0;
      return word[W-1-k];
   endfunction

   always @(negedge sclk) begin
      for (int g = 0; g < 2; g++) model_step(g);
   end

   always @(posedge sclk) begin
      if (chk_en) begin
         for (int g = 0; g < 2; g++) begin
            check(tg(g, "ready"), 64'(ready[g]), 64'(m_ready[g]));
            check(tg(g, "ws"),    64'(ws[g]),    64'(exp_ws(g)));
            check(tg(g, "sdata"), 64'(sd[g]),    64'(exp_sd(g)));
            check(tg(g, "fstart"), 64'(fs[g]),   64'(m_fs[g]));
            check(tg(g, "underrun"), 64'(ur[g]), 64'(m_ur[g]));
         end
      end
   end

   task automatic wait_pos(input int g, input int p);
      int n;
      n = 0;
      while (pos[g] != p && n < 200) begin
         @(posedge sclk);
         n++;
      end
      if (pos[g] != p) check(tg(g, "wait_pos"), 64'(pos[g]), 64'(p));
   endtask

   task automatic next_frame(input int g);
      @(posedge sclk);
      wait_pos(g, 0);
   endtask

   task automatic send(input int g, input logic [W-1:0] l, input logic [W-1:0] r);
      int a0;
      int n;
      a0 = acc_cnt[g];
      n = 0;
      l_in[g] = l;
      r_in[g] = r;
      valid[g] = 1'b1;
      do begin
         @(posedge sclk);
         n++;
      end while (acc_cnt[g] == a0 && n < 200);
      valid[g] = 1'b0;
      if (acc_cnt[g] == a0) check(tg(g, "accept timeout"), 64'(acc_cnt[g] - a0), 64'd1);
   endtask

   // called at the start of a cnt=0 period; returns at the start of the next one
   task automatic capture_frame(input int g, input logic [W-1:0] l, input logic [W-1:0] r,
                                input string tag);
      int s;
      logic [63:0] got;
      logic [63:0] exp;
      s = slot_of(g);
      got = '0;
      exp = ((64'(l) << (s - W)) << s) | (64'(r) << (s - W));
      for (int i = 0; i < 2 * s; i++) begin
         got = {got[62:0], sd[g]};
         @(posedge sclk);
      end
      check(tg(g, tag), got, exp);
   endtask

   task automatic run_inst(input int g);
      int s;
      int f;
      int a0;
      logic [W-1:0] a_l, a_r, b_l, b_r;
      s = slot_of(g);
      f = 2 * s;
      a_l = (g == 0) ? 16'hA5C3 : 16'h8001;
      a_r = (g == 0) ? 16'h3C5A : 16'h7FFF;

      @(posedge sclk);
      repeat (2) @(posedge sclk);
      check(tg(g, "rst ready"), 64'(ready[g]), 64'd0);
      check(tg(g, "rst ws"),    64'(ws[g]),    64'd0);
      check(tg(g, "rst sdata"), 64'(sd[g]),    64'd0);
      check(tg(g, "rst underrun"), 64'(ur[g]), 64'd0);
      rst_n[g] = 1'b1;
      @(posedge sclk);
      check(tg(g, "first ready"),    64'(ready[g]), 64'd1);
      check(tg(g, "first fstart"),   64'(fs[g]),    64'd1);
      check(tg(g, "first underrun"), 64'(ur[g]),    64'd1);

      send(g, a_l, a_r);
      wait_pos(g, 0);
      check(tg(g, "frame2 underrun"), 64'(ur[g]), 64'd0);
      check(tg(g, "frame2 fstart"),   64'(fs[g]), 64'd1);
      capture_frame(g, a_l, a_r, "frame2 data");

      for (int n = 1; n <= 8; n++) send(g, W'(n), ~W'(n));
      next_frame(g);
      check(tg(g, "last pair underrun"), 64'(ur[g]), 64'd0);
      capture_frame(g, W'(8), ~W'(8), "last pair data");
      check(tg(g, "starve underrun"), 64'(ur[g]), 64'd1);
      check(tg(g, "starve fstart"),   64'(fs[g]), 64'd1);
      b_l = W'($urandom());
      b_r = W'($urandom());
      send(g, b_l, b_r);
      wait_pos(g, 0);
      check(tg(g, "resume underrun"), 64'(ur[g]), 64'd0);
      capture_frame(g, b_l, b_r, "resume data");

      b_l = W'($urandom());
      b_r = W'($urandom());
      wait_pos(g, f - 2);
      a0 = acc_cnt[g];
      l_in[g] = b_l;
      r_in[g] = b_r;
      valid[g] = 1'b1;
      @(posedge sclk);
      valid[g] = 1'b0;
      check(tg(g, "accept at last-1"), 64'(acc_cnt[g] - a0), 64'd1);
      @(posedge sclk);
      check(tg(g, "late-1 underrun"), 64'(ur[g]), 64'd0);
      capture_frame(g, b_l, b_r, "late-1 data");
      check(tg(g, "after late-1 underrun"), 64'(ur[g]), 64'd1);

      b_l = W'($urandom());
      b_r = W'($urandom());
      wait_pos(g, f - 1);
      a0 = acc_cnt[g];
      l_in[g] = b_l;
      r_in[g] = b_r;
      valid[g] = 1'b1;
      @(posedge sclk);
      valid[g] = 1'b0;
      check(tg(g, "accept at load"), 64'(acc_cnt[g] - a0), 64'd1);
      check(tg(g, "load-accept underrun"), 64'(ur[g]), 64'd1);
      capture_frame(g, '0, '0, "load-accept silence");
      check(tg(g, "deferred underrun"), 64'(ur[g]), 64'd0);
      capture_frame(g, b_l, b_r, "deferred data");

      repeat (12) begin
         int gap;
         gap = $urandom_range(0, f + s);
         for (int i = 0; i < gap; i++) begin
            if (!m_ready[g] && $urandom_range(0, 3) == 0) begin
               l_in[g] = W'($urandom());
               r_in[g] = W'($urandom());
               valid[g] = 1'b1;
            end else begin
               valid[g] = 1'b0;
            end
            @(posedge sclk);
         end
         valid[g] = 1'b0;
         send(g, W'($urandom()), W'($urandom()));
      end

      next_frame(g);
      send(g, W'($urandom()), W'($urandom()));
      wait_pos(g, s + 4);
      rst_n[g] = 1'b0;
      @(posedge sclk);
      check(tg(g, "midrst ws"),    64'(ws[g]),    64'd0);
      check(tg(g, "midrst sdata"), 64'(sd[g]),    64'd0);
      check(tg(g, "midrst ready"), 64'(ready[g]), 64'd0);
      rst_n[g] = 1'b1;
      @(posedge sclk);
      check(tg(g, "post-rst underrun"), 64'(ur[g]), 64'd1);
      check(tg(g, "post-rst fstart"),   64'(fs[g]), 64'd1);
      b_l = W'($urandom());
      b_r = W'($urandom());
      l_in[g] = b_l;
      r_in[g] = b_r;
      valid[g] = 1'b1;
      capture_frame(g, '0, '0, "post-rst silence");
      valid[g] = 1'b0;
      check(tg(g, "post-rst next underrun"), 64'(ur[g]), 64'd0);
      capture_frame(g, b_l, b_r, "post-rst data");
      repeat (4) @(posedge sclk);
   endtask

   initial begin
      rst_n = 2'b00;
      valid = 2'b00;
      for (int g = 0; g < 2; g++) begin
         l_in[g] = '0;
         r_in[g] = '0;
      end
      @(negedge sclk);
      chk_en = 1'b1;
      fork
         run_inst(0);
         run_inst(1);
      join
      repeat (2) @(posedge sclk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "time limit reached");
   end

endmodule
